// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into WIDTH-cycle pulses separated by at least GAP low cycles.
// Define PULSE_STRETCHER_QUEUE_EN to queue requests that arrive while a pulse is in progress.
module pulse_stretcher #(
  parameter int WIDTH    = 4,
  parameter int GAP      = 2,
  parameter int PEND_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy,
  output logic drop
);

  localparam int MAX_WG = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW     = $clog2(MAX_WG + 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_q, busy_q, drop_q, drop_d;
  logic            cnt_zero, accept;

`ifdef PULSE_STRETCHER_QUEUE_EN
  localparam int PW = $clog2(PEND_MAX + 1);
  logic [PW-1:0]   pend_q, pend_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_d   = 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
    pend_d   = pend_q;
`endif
    cnt_zero = (cnt_q == '0);
    // A new pulse may begin in IDLE or on the last cycle of the preceding pulse/gap.
    accept   = (state_q == S_IDLE) ||
               (cnt_zero && ((state_q == S_GAP) || ((state_q == S_HIGH) && (GAP == 0))));

    if (accept) begin
`ifdef PULSE_STRETCHER_QUEUE_EN
      if (pend_q != '0) begin
        state_d = S_HIGH;
        cnt_d   = CW'(WIDTH - 1);
        if (!in) begin
          pend_d = pend_q - PW'(1);
        end
      end else if (in) begin
        state_d = S_HIGH;
        cnt_d   = CW'(WIDTH - 1);
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
`else
      if (in) begin
        state_d = S_HIGH;
        cnt_d   = CW'(WIDTH - 1);
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
`endif
    end else begin
      case (state_q)
        S_HIGH: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = S_GAP;
            cnt_d   = CW'(GAP - 1);
          end
        end
        default: cnt_d = cnt_q - CW'(1);
      endcase

      if (in) begin
`ifdef PULSE_STRETCHER_QUEUE_EN
        if (pend_q == PW'(PEND_MAX)) begin
          drop_d = 1'b1;
        end else begin
          pend_d = pend_q + PW'(1);
        end
`else
        drop_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
      pend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= (state_d == S_HIGH);
      busy_q  <= (state_d != S_IDLE);
      drop_q  <= drop_d;
`ifdef PULSE_STRETCHER_QUEUE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign drop = drop_q;

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle request pulses, such as those produced by the rising-edge detector, back into level pulses. Each pulse is held high for a programmable number of cycles and followed by a guaranteed minimum low time. Requests that arrive while a pulse is in progress are queued in a saturating counter. The block sits downstream of edge-detection logic and drives slow consumers (LED drivers, handshake strobes, external pins).

## Interface
- WIDTH, 4: cycles `out` is held high per request; legal range ≥1.
- GAP, 2: minimum cycles `out` is low between two pulses; legal range ≥0.
- PEND_MAX, 3: maximum queued requests; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in  input  1  request; every cycle sampled high is one request.
- out  output  1  stretched pulse; registered.
- busy  output  1  high whenever the FSM is not in IDLE; registered.
- drop  output  1  one-cycle strobe when a request is discarded; registered.

## Operation
- FSM states: IDLE, HIGH, GAP.
  - `out` = 1 only in HIGH.
  - `busy` = 1 in HIGH and GAP.
- Down-counter `cnt` is $clog2(max(WIDTH,GAP)+1) bits wide.
- Pending counter `pend` is $clog2(PEND_MAX+1) bits wide and saturates at PEND_MAX.
- Accept cycle: any cycle in IDLE, the HIGH cycle with cnt==0 when GAP==0, or the GAP cycle with cnt==0.
- IDLE:
  - If `in`, go to HIGH with cnt=WIDTH-1.
  - Otherwise stay in IDLE.
- HIGH:
  - While cnt>0, decrement.
  - At cnt==0 with GAP>0, go to GAP with cnt=GAP-1.
  - At cnt==0 with GAP==0, this is an accept cycle.
- GAP:
  - While cnt>0, decrement.
  - At cnt==0, this is an accept cycle.
- At an accept cycle:
  - If pend>0, start HIGH (cnt=WIDTH-1) and decrement `pend`.
  - Else if `in`, start HIGH.
  - Otherwise go to IDLE.
- Simultaneous `in`=1 while a queued request is consumed: the new request is queued, so `pend` is unchanged net. This applies even when pend==PEND_MAX; no drop.
- `in`=1 in a non-accept cycle: increment `pend`.
  - If pend==PEND_MAX, the request is lost; pulse `drop` for one cycle.
- Requests are served in order, one pulse per request; no pulse merging.

## Timing
- Reset values: state IDLE; `out`, `busy`, `drop` = 0; `pend` = 0; `cnt` = 0.
- Reset mid-operation: all outputs are 0 after the reset edge, and queued requests are discarded.
- Latency: `in` sampled at edge n gives `out` high after edges n..n+WIDTH-1, then low for GAP cycles.
- `busy` is high after edges n..n+WIDTH+GAP-1.
- Back-to-back queued pulses are spaced exactly WIDTH+GAP cycles from rising edge to rising edge.
- `drop` is asserted in the cycle after the edge that sampled the lost request, and lasts one cycle.

## Configuration
- PULSE_STRETCHER_QUEUE_EN defined: pending counter present; behaviour as above.
- PULSE_STRETCHER_QUEUE_EN undefined:
  - No `pend` register.
  - `in`=1 in any non-accept cycle is discarded with a `drop` strobe.
  - `in`=1 in an accept cycle starts a new pulse as normal.

## Test plan
Defaults apply unless stated: WIDTH=4, GAP=2, PEND_MAX=3, queue enabled.
- Reset: hold rst for 2 cycles with `in` toggling → `out`=`busy`=`drop`=0 throughout and the cycle after release.
- Single request sampled at edge n → `out`=1 after edges n..n+3; `out`=0 after n+4 and n+5; `busy` falls after n+6.
- Second request at edge n+2 → second `out` pulse after edges n+6..n+9; `drop` never asserts.
- Requests at edges n..n+4 (five consecutive) → pulses start at n, n+6, n+12, n+18; `drop` high for exactly one cycle after edge n+4.
- rst asserted at edge n+2 during HIGH with pend=2 → `out`=0 after n+2; no further pulses.
- Queue disabled:
  - Request at edge n+2 → `drop` after n+2; no second pulse.
  - Request at edge n+6 (terminal GAP cycle) → accepted; `out` high after n+6..n+9.
